burst_transmit: RTL
===================

BURST_TRANSMIT -- requirements
Module: burst_transmit

Interface
REQ-001 SHALL have parameter IWIDTH, default 32, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 6, number of stored words; any value >= 2, not necessarily a power of two.
REQ-003 SHALL have parameter LWIDTH, default 8, width of the burst-length field; localparam AWIDTH = clog2(DEPTH).
REQ-004 SHALL have port t_clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port t_rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port t_i_wr_en  input  1  load strobe for word storage.
REQ-007 SHALL have port t_i_wr_addr  input  AWIDTH  load address.
REQ-008 SHALL have port t_i_wr_data  input  IWIDTH  load data.
REQ-009 SHALL have port t_i_syn  input  1  burst start request.
REQ-010 SHALL have port t_i_start  input  AWIDTH  first address of the burst.
REQ-011 SHALL have port t_i_len  input  LWIDTH  number of beats in the burst.
REQ-012 SHALL have port t_i_ready  input  1  downstream ready.
REQ-013 SHALL have port t_o_instr  output  IWIDTH  current beat data.
REQ-014 SHALL have port t_o_valid  output  1  beat data valid.
REQ-015 SHALL have port t_o_last  output  1  current beat is final beat of burst.
REQ-016 SHALL have port t_o_ack  output  1  one-cycle burst-complete pulse.
REQ-017 SHALL have port t_o_busy  output  1  high in SEND and DONE.
REQ-018 SHALL have port t_o_parity  output  1  even parity of t_o_instr (see Configuration).

Function
REQ-019 SHALL implement FSM IDLE -> SEND -> DONE -> IDLE.
REQ-020 In IDLE, a high t_i_wr_en at a clock edge SHALL write t_i_wr_data to t_i_wr_addr; addresses >= DEPTH are ignored; writes in SEND/DONE are ignored.
REQ-021 In IDLE, t_i_syn high with t_i_len != 0 at an edge SHALL capture t_i_start and t_i_len and enter SEND; t_o_valid rises the following cycle with the word at t_i_start.
REQ-022 In IDLE, t_i_syn with t_i_len == 0 SHALL be ignored (no state change, no ack).
REQ-023 Simultaneous t_i_wr_en and t_i_syn in IDLE SHALL perform the write first; the burst reads the new value if the addresses match.
REQ-024 A beat transfers on an edge where t_o_valid and t_i_ready are both high; t_o_instr/t_o_last SHALL hold stable while t_o_valid high and t_i_ready low.
REQ-025 After each transfer the address SHALL advance by one, wrapping from DEPTH-1 to 0.
REQ-026 t_o_last SHALL be high exactly during the beat for which the remaining-beat count equals 1.
REQ-027 Transfer of the last beat SHALL enter DONE with t_o_valid low; DONE lasts one cycle with t_o_ack=1, then IDLE.
REQ-028 t_i_syn SHALL be ignored in SEND and DONE; level-held t_i_syn starts a new burst on the first IDLE cycle (back-to-back bursts separated by one DONE cycle).
REQ-029 t_i_len > DEPTH SHALL be legal; the burst wraps and re-sends words.

Reset
REQ-030 On t_rst low, asynchronously: state IDLE, t_o_instr=0, t_o_valid=0, t_o_last=0, t_o_ack=0, t_o_busy=0, t_o_parity=0, counters 0.
REQ-031 Reset mid-burst SHALL abort immediately with no ack; stored words need not be cleared.

Configuration
REQ-032 With macro BURST_TRANSMIT_PARITY_EN defined, t_o_parity SHALL equal XOR-reduction of t_o_instr, registered alongside it; undefined, t_o_parity SHALL be constant 0 and no parity logic synthesised.

Structure
REQ-033 Shared package tx_pkg SHALL hold the FSM state encoding (IDLE, SEND, DONE) and the clog2 helper.
REQ-034 Storage SHALL be sub-module tx_mem (1 write port, 1 asynchronous read port, DEPTH x IWIDTH).

Verification
REQ-035 Load words 0xA0..0xA5 at addr 0..5, syn start=0 len=6, ready=1 -> beats A0..A5 on 6 consecutive cycles, last only with A5, ack 1 cycle after.
REQ-036 start=4 len=4 -> beats A4,A5,A0,A1 (wrap), last with A1.
REQ-037 len=3, ready low for 2 cycles on beat 2 -> beat 2 data held, no duplication or loss, total 3 transfers.
REQ-038 syn with len=0 -> no valid, no ack, busy stays 0; write during SEND to addr 0 -> memory unchanged after burst.
REQ-039 Reset asserted after beat 2 of len=6 -> all outputs 0 asynchronously, no ack; new burst after release works.
REQ-040 With BURST_TRANSMIT_PARITY_EN, word 0x00000007 -> t_o_parity=1; without macro -> 0.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the burst transmitter: FSM state encoding and ceil-log2 helper.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_e;

  // Never returns less than 1 so a 2-entry store still gets a 1-bit address.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tx_mem.sv
// Word store for burst_transmit: one synchronous write port, one asynchronous read port.
// Out-of-range write addresses are dropped; out-of-range reads return zero.
module tx_mem #(
  parameter int IWIDTH = 32,
  parameter int DEPTH  = 6,
  parameter int AWIDTH = 3
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_wr_addr,
  input  logic [IWIDTH-1:0] i_wr_data,
  input  logic [AWIDTH-1:0] i_rd_addr,
  output logic [IWIDTH-1:0] o_rd_data
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  logic [IWIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we && (i_wr_addr <= LAST_ADDR)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = (i_rd_addr <= LAST_ADDR) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/burst_transmit.sv
// Replays a run of stored words as a valid/ready burst with last/ack framing.
// Optional registered even parity on the beat data when BURST_TRANSMIT_PARITY_EN is defined.
module burst_transmit
  import tx_pkg::*;
#(
  parameter int  IWIDTH = 32,
  parameter int  DEPTH  = 6,
  parameter int  LWIDTH = 8,
  localparam int AWIDTH = clog2(DEPTH)
) (
  input  logic              t_clk,
  input  logic              t_rst,
  input  logic              t_i_wr_en,
  input  logic [AWIDTH-1:0] t_i_wr_addr,
  input  logic [IWIDTH-1:0] t_i_wr_data,
  input  logic              t_i_syn,
  input  logic [AWIDTH-1:0] t_i_start,
  input  logic [LWIDTH-1:0] t_i_len,
  input  logic              t_i_ready,
  output logic [IWIDTH-1:0] t_o_instr,
  output logic              t_o_valid,
  output logic              t_o_last,
  output logic              t_o_ack,
  output logic              t_o_busy,
  output logic              t_o_parity
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
  localparam logic [LWIDTH-1:0] ONE       = LWIDTH'(1);
  localparam logic [LWIDTH-1:0] TWO       = LWIDTH'(2);

  tx_state_e         r_state, w_state_nxt;
  logic [AWIDTH-1:0] r_addr, w_next_addr, w_rd_addr;
  logic [LWIDTH-1:0] r_cnt;
  logic [IWIDTH-1:0] r_instr, w_rd_data, w_beat_data;
  logic              r_valid, r_last;
  logic              w_mem_we, w_fire, w_load, w_step, w_end;

  assign w_fire      = r_valid && t_i_ready;
  assign w_mem_we    = t_i_wr_en && (r_state == IDLE);
  assign w_next_addr = (r_addr >= LAST_ADDR) ? '0 : r_addr + 1'b1;
  assign w_rd_addr   = (r_state == IDLE) ? t_i_start : w_next_addr;

  // Same-edge write forwarding so a burst started alongside a write sees the new word.
  assign w_beat_data = (w_mem_we && (t_i_wr_addr <= LAST_ADDR) && (t_i_wr_addr == w_rd_addr))
                       ? t_i_wr_data : w_rd_data;

  tx_mem #(
    .IWIDTH(IWIDTH),
    .DEPTH (DEPTH),
    .AWIDTH(AWIDTH)
  ) u_mem (
    .i_clk    (t_clk),
    .i_we     (w_mem_we),
    .i_wr_addr(t_i_wr_addr),
    .i_wr_data(t_i_wr_data),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_rd_data)
  );

  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_end       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (t_i_syn && (t_i_len != '0)) begin
          w_load      = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_fire) begin
          if (r_cnt == ONE) begin
            w_end       = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_addr/r_cnt describe the beat currently presented on t_o_instr.
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_addr  <= t_i_start;
      r_cnt   <= t_i_len;
      r_instr <= w_beat_data;
      r_valid <= 1'b1;
      r_last  <= (t_i_len == ONE);
    end else if (w_step) begin
      r_addr  <= w_next_addr;
      r_cnt   <= r_cnt - ONE;
      r_instr <= w_beat_data;
      r_last  <= (r_cnt == TWO);
    end else if (w_end) begin
      r_cnt   <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

`ifdef BURST_TRANSMIT_PARITY_EN
  logic r_parity;

  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst)                r_parity <= 1'b0;
    else if (w_load || w_step) r_parity <= ^w_beat_data;
    else if (w_end)            r_parity <= 1'b0;
  end

  assign t_o_parity = r_parity;
`else
  assign t_o_parity = 1'b0;
`endif

  assign t_o_instr = r_instr;
  assign t_o_valid = r_valid;
  assign t_o_last  = r_last;
  assign t_o_ack   = (r_state == DONE);
  assign t_o_busy  = (r_state != IDLE);

endmodule
